// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 target; oversamples the pins in clk_i, delivers received words as pulses
// and serialises words from a one-entry transmit buffer onto MISO.
module spi_slave #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = '1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              SCLK_i,
    input  logic              SS_i,
    input  logic              MOSI_i,
    output logic              MISO_o,
    output logic              MISO_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_active_o,
    output logic              underrun_o,
    output logic              abort_o
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_prev_q, sclk_prev_q;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d, buf_q, buf_d, rx_data_q, rx_data_d;
    logic [DATA_W-2:0]      rx_sr_q, rx_sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   buf_full_q, buf_full_d, pend_q, pend_d;
    logic                   rx_valid_q, underrun_q, abort_q;
    logic                   ss_s, sclk_s, mosi_s, ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic                   in_shift, sample, done, load, shift, wr;

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // SS rise outranks any SCLK edge seen in the same cycle
    assign in_shift = state_q == SHIFT;
    assign sample   = in_shift & sclk_rise & ~ss_rise;
    assign done     = sample & (cnt_q == CW'(DATA_W - 1));
    assign load     = (state_q == LOAD) | (in_shift & sclk_fall & pend_q & ~ss_rise);
    assign shift    = in_shift & sclk_fall & ~pend_q & ~ss_rise;
    assign wr       = tx_valid_i & ~buf_full_q;

    always_comb begin
        state_d    = (state_q == IDLE) ? (ss_fall ? LOAD : IDLE) : (ss_rise ? IDLE : SHIFT);
        tx_sr_d    = load ? (buf_full_q ? buf_q : IDLE_FILL)
                   : shift ? {tx_sr_q[DATA_W-2:0], 1'b0} : tx_sr_q;
        rx_sr_d    = sample ? {rx_sr_q[DATA_W-3:0], mosi_s} : rx_sr_q;
        rx_data_d  = done ? {rx_sr_q, mosi_s} : rx_data_q;
        cnt_d      = (state_q == LOAD || done) ? '0 : sample ? cnt_q + CW'(1) : cnt_q;
        pend_d     = done | (pend_q & in_shift & ~load & ~ss_rise);
        buf_full_d = wr | (buf_full_q & ~load);
        buf_d      = wr ? tx_data_i : buf_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_q       <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            buf_full_q  <= buf_full_d;
            buf_q       <= buf_d;
            rx_valid_q  <= done;
            underrun_q  <= load & ~buf_full_q;
            abort_q     <= in_shift & ss_rise & (cnt_q != '0);
        end
    end

    assign MISO_o         = tx_sr_q[DATA_W-1];
    assign MISO_oe_o      = state_q != IDLE;
    assign tx_ready_o     = ~buf_full_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign frame_active_o = ~ss_s;
    assign underrun_o     = underrun_q;
    assign abort_o        = abort_q;
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that is the far end of the team's spi_master.
- Serves as the bench model of a flash, shift-register or sensor target, and can be reused as an on-chip target.
- Oversamples SCLK_i, SS_i and MOSI_i in the clk_i domain, deserialises received bytes to a pulse interface, and serialises transmit bytes from a one-entry valid/ready buffer onto MISO_o.

Parameters:
- DATA_W, 8: bits per SPI word.
- SYNC_STAGES, 2: flip-flop synchroniser depth on SCLK_i, SS_i and MOSI_i (legal range 2..3).
- IDLE_FILL, 8'hFF: word shifted out when the transmit buffer is empty at a load point.

Ports:
- clk_i  input  1  system clock; must run at least 8x the SCLK_i frequency.
- rst_i  input  1  asynchronous, active-high reset.
- SCLK_i  input  1  SPI clock from the master.
- SS_i  input  1  slave select, active low.
- MOSI_i  input  1  master out, slave in.
- MISO_o  output  1  slave out, master in.
- MISO_oe_o  output  1  MISO output enable; the pad tri-states when this is 0.
- tx_data_i  input  DATA_W  next word to transmit.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  transmit buffer is empty.
- rx_data_o  output  DATA_W  last received word.
- rx_valid_o  output  1  one-cycle pulse: rx_data_o has been updated.
- frame_active_o  output  1  SS is asserted (synchronised).
- underrun_o  output  1  one-cycle pulse: IDLE_FILL was loaded because the buffer was empty.
- abort_o  output  1  one-cycle pulse: SS deasserted mid-word.

Behaviour:
- Reset values (asynchronous, all held while rst_i=1):
  - MISO_o=0, MISO_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, frame_active_o=0, underrun_o=0, abort_o=0.
  - Synchroniser flops: SS=1, SCLK=0, MOSI=0.
  - Transmit buffer empty, bit counter 0, state IDLE.
- Edge detect: rise/fall are computed from the last synchroniser stage against a one-flop delayed copy. A pin edge is acted on SYNC_STAGES+1 cycles after it occurs.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: MISO_oe_o=0. On SS fall, go to LOAD.
  - LOAD (exactly 1 cycle):
    - Shift register <= buffer if full (buffer becomes empty, tx_ready_o=1 next cycle); otherwise shift register <= IDLE_FILL and underrun_o pulses.
    - Bit counter <= 0, MISO_oe_o=1, MISO_o=shift register MSB from the next cycle. Then go to SHIFT.
  - SHIFT, on SCLK rise: sample MOSI into rx shift register LSB; counter++.
    - When the counter reaches DATA_W, in the same cycle: rx_data_o <= assembled word, rx_valid_o=1 for one cycle, counter <= 0, and set a pending-load flag.
  - SHIFT, on SCLK fall:
    - If pending-load is set: reload the tx shift register exactly as in LOAD (including the underrun rule) and clear the flag.
    - Otherwise shift the tx register left by 1. MISO_o always reflects the register MSB.
  - SHIFT, on SS rise:
    - If counter != 0: abort_o pulses and the partial rx word is discarded; rx_valid_o does not fire.
    - In all cases go to IDLE, MISO_oe_o=0, pending-load cleared.
    - A word already moved into the shift register is lost and is not returned to the buffer.
- Transmit buffer:
  - Captures tx_data_i when tx_valid_i && tx_ready_o; tx_ready_o falls the next cycle.
  - A write and a load in the same cycle with the buffer empty: the load takes IDLE_FILL (underrun) and the write lands in the buffer for the next word.
  - The buffer holds its contents across frames.
- Simultaneous SCLK rise and SS rise in one cycle: SS rise wins; the sample is discarded.
- SCLK edges while in IDLE are ignored.
- Timing requirement on the master: SS fall to first SCLK rise must be at least SYNC_STAGES+3 clk_i cycles.
- frame_active_o is the synchronised, inverted SS.

Test Plan:
- Single byte: preload tx 8'hA5, master sends 8'h3C with an 8 MHz SCLK and a 100 MHz clk_i -> master receives 8'hA5; rx_valid_o pulses once with rx_data_o=8'h3C; tx_ready_o returns to 1 after LOAD.
- Four-byte burst: stream tx 11,22,33,44 with tx_valid_i held while tx_ready_o is high; master sends 9F,00,00,00 -> master reads 11,22,33,44; rx_valid_o pulses 4 times with 9F,00,00,00; no underrun_o.
- Underrun: empty buffer, 2-byte frame -> master reads FF,FF; underrun_o pulses twice. Writing 8'h5A during byte 1 -> byte 2 reads 5A with a single underrun_o pulse.
- Abort: SS rises after 3 SCLK edges -> abort_o pulses once, no rx_valid_o, MISO_oe_o=0; the next frame starts cleanly at bit 7.
- Async reset mid-word (after 5 bits) -> all outputs take their reset values immediately; after release, an 8'hC3 frame is received correctly.
- Idle SCLK toggling with SS high -> no rx_valid_o, MISO_oe_o stays 0, buffer contents unchanged.
